rock_intensity_ctrl: RTL and testbench
======================================

Name: rock_intensity_ctrl

Overview:
- Closed-loop rocking scheduler, clocked on `slow`, between the heart-rate stress detector and the cradle motor driver.
- Consumes the detector's stable-sample pulse and trend flags (`gedaald` = calmer, `error` = more stressed).
- Raises or lowers a 3-bit rocking intensity and generates the motor swing square wave at the matching rate.
- Ends the session once the baby stays calm; flags a fault if the heart-rate stream stops settling.

Parameters:
- MAX_LEVEL, 7: highest intensity; saturation bound.
- START_LEVEL, 3: intensity loaded when a session starts.
- CALM_COUNT, 2: consecutive calm evaluations needed for one step down.
- TIMEOUT, 64: maximum `slow` cycles in RUN without an evaluation before FAULT.
- BASE_HALF, 16: swing half-period in cycles at level 0.
- STEP_HALF, 2: half-period reduction per level. Constraint: BASE_HALF - MAX_LEVEL*STEP_HALF >= 2.

Ports:
- slow, in, 1: clock; all state changes on the rising edge.
- resetSlower, in, 1: reset, asynchronous, active-high.
- enable, in, 1: session request (level-sensitive).
- gelijkPuls, in, 1: stable-sample pulse from the detector; may last several cycles.
- gedaald, in, 1: calmer flag; valid while gelijkPuls is high.
- error, in, 1: more-stressed flag; valid while gelijkPuls is high.
- level, out, 3: current rocking intensity.
- swing, out, 1: motor direction square wave.
- busy, out, 1: high in START, RUN, STEP and DONE.
- fault, out, 1: timeout indication.

Behaviour:
- Reset values: state IDLE, level=0, swing=0, busy=0, fault=0, calm counter=0, timeout counter=0, swing counter=0.
- Evaluation event: gelijkPuls is registered once; an event fires on the cycle a rising edge is detected (gelijkPuls=1, registered copy=0).
  - One event per pulse regardless of pulse length.
  - gedaald and error are sampled on the event cycle.
- IDLE:
  - level=0, swing=0.
  - enable=1 -> START.
- START (1 cycle): level<=START_LEVEL; clear calm and timeout counters -> RUN.
- RUN:
  - Timeout counter increments each cycle and clears on every event.
  - Reaching TIMEOUT-1 without an event -> FAULT.
  - enable=0 -> IDLE (abort); level<=0 on the transition.
  - Event with error=1, gedaald=0:
    - calm counter<=0.
    - level<=min(level+1, MAX_LEVEL).
  - Event with gedaald=1, error=0:
    - calm counter +1.
    - On reaching CALM_COUNT, clear the counter, then:
      - level>0 -> level-1.
      - level==0 -> DONE.
  - Event with both flags equal (00 or 11): no level change; calm counter unchanged.
- STEP: every level change passes through one STEP cycle, which restarts the swing counter, then returns to RUN. Events arriving in STEP are dropped.
- DONE (1 cycle): busy=1, level=0 -> IDLE.
  - Re-entry requires enable to have been low for at least one cycle (edge-armed flag set in IDLE when enable=0).
- FAULT:
  - fault=1, level=0, swing=0, busy=0.
  - Held until enable=0, then -> IDLE with fault cleared.
- Swing:
  - half = BASE_HALF - level*STEP_HALF, computed in 6 bits.
  - Counter counts 0..half-1; swing toggles on wrap.
  - At level 0, or in IDLE/FAULT, counter and swing are held at 0.
  - On a level change the counter restarts at 0 and swing keeps its current value.
- Priority within one cycle: resetSlower > timeout > enable=0 > event.
- Reset mid-session: immediate asynchronous return to the reset values; no output glitch beyond the reset assertion.
- Level arithmetic saturates at both ends; no wrap.

Decomposition:
- Shared package rock_pkg:
  - State enum: IDLE, START, RUN, STEP, DONE, FAULT.
  - Level width constant (3).
  - Default values for MAX_LEVEL, START_LEVEL, CALM_COUNT, TIMEOUT, BASE_HALF, STEP_HALF.
- Sub-module swing_gen:
  - Inputs: slow, resetSlower, level, run, restart.
  - Output: swing.
  - Contains the half-period computation and counter.
- rock_intensity_ctrl holds the FSM, edge detector, calm counter and timeout counter.

Test Plan:
- Reset then enable=1 -> START, then RUN two cycles after enable; level=3, busy=1; swing toggles every 10 cycles.
- In RUN, five error pulses (each 3 cycles long) -> level 4,5,6,7,7; exactly one step per pulse; swing half-period 2 at level 7.
- From level 1, gedaald pulses: the second pulse -> level 0, the fourth pulse -> DONE then IDLE, busy=0; a gedaald,error=1,1 pulse in between causes no change.
- No gelijkPuls for 64 cycles in RUN -> fault=1, level=0, swing=0; drop enable -> IDLE, fault=0.
- Assert resetSlower mid-RUN at level 5 with swing=1 -> all outputs 0 immediately, asynchronously; after release, with enable still high, the bench drops then re-raises enable -> START, level=3.
- enable=0 while an error pulse arrives in the same cycle -> IDLE, level=0; the pulse is ignored.

Source files
------------

// File: rtl/rock_pkg.sv
// Shared definitions for the cradle rocking scheduler.
//   - state_t      : scheduler FSM states
//   - LEVEL_W      : width of the rocking intensity
//   - HALF_W       : width of the swing half-period arithmetic
//   - DEF_*        : default parameter values for the scheduler
//   - half_period(): swing half-period in cycles for a given intensity
package rock_pkg;

  localparam int LEVEL_W = 3;
  localparam int HALF_W  = 6;

  localparam int DEF_MAX_LEVEL   = 7;
  localparam int DEF_START_LEVEL = 3;
  localparam int DEF_CALM_COUNT  = 2;
  localparam int DEF_TIMEOUT     = 64;
  localparam int DEF_BASE_HALF   = 16;
  localparam int DEF_STEP_HALF   = 2;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    STEP,
    DONE,
    FAULT
  } state_t;

  // Higher intensity rocks faster: each level shortens the half-period.
  function automatic logic [HALF_W-1:0] half_period(input level_t lvl,
                                                     input int     base,
                                                     input int     step);
    return HALF_W'(base - step * int'(lvl));
  endfunction

endpackage

// File: rtl/swing_gen.sv
// Motor swing square-wave generator.
// Ports:
//   slow        in  clock
//   resetSlower in  asynchronous active-high reset
//   level       in  current rocking intensity (sets the half-period)
//   run         in  high while the scheduler is actively rocking
//   restart     in  restart the half-period counter (swing keeps its value)
//   swing       out motor direction square wave
module swing_gen
  import rock_pkg::*;
#(
  parameter int BASE_HALF = DEF_BASE_HALF,
  parameter int STEP_HALF = DEF_STEP_HALF
) (
  input  logic               slow,
  input  logic               resetSlower,
  input  logic [LEVEL_W-1:0] level,
  input  logic               run,
  input  logic               restart,
  output logic               swing
);

  logic [HALF_W-1:0] half;
  logic [HALF_W-1:0] cnt;
  logic              swing_q;
  logic              hold;

  assign half = half_period(level, BASE_HALF, STEP_HALF);
  assign hold = !run || (level == '0);

  // NOTE: every register here is assigned with <= so that all flops sample
  // the same pre-edge values; blocking assignments would make the result
  // depend on statement order inside the block.
  always_ff @(posedge slow or posedge resetSlower) begin
    if (resetSlower) begin
      cnt     <= '0;
      swing_q <= 1'b0;
    end else if (hold) begin
      cnt     <= '0;
      swing_q <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
    end else if (cnt == half - 1'b1) begin
      cnt     <= '0;
      swing_q <= ~swing_q;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

  // The register clears one edge after the scheduler stops rocking; masking
  // with hold drives the motor line low on the same edge as the state change.
  assign swing = swing_q & ~hold;

endmodule

// File: rtl/rock_intensity_ctrl.sv
// Closed-loop rocking scheduler between the heart-rate stress detector and
// the cradle motor driver.
// Ports:
//   slow        in  clock
//   resetSlower in  asynchronous active-high reset
//   enable      in  session request (level-sensitive)
//   gelijkPuls  in  stable-sample pulse from the detector (may be long)
//   gedaald     in  calmer flag, valid while gelijkPuls is high
//   error       in  more-stressed flag, valid while gelijkPuls is high
//   level       out current rocking intensity
//   swing       out motor direction square wave
//   busy        out high in START, RUN, STEP and DONE
//   fault       out heart-rate stream stopped settling (timeout)
module rock_intensity_ctrl
  import rock_pkg::*;
#(
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int START_LEVEL = DEF_START_LEVEL,
  parameter int CALM_COUNT  = DEF_CALM_COUNT,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int BASE_HALF   = DEF_BASE_HALF,
  parameter int STEP_HALF   = DEF_STEP_HALF
) (
  input  logic               slow,
  input  logic               resetSlower,
  input  logic               enable,
  input  logic               gelijkPuls,
  input  logic               gedaald,
  input  logic               error,
  output logic [LEVEL_W-1:0] level,
  output logic               swing,
  output logic               busy,
  output logic               fault
);

  localparam int     CALM_W    = $clog2(CALM_COUNT + 1);
  localparam int     TMO_W     = $clog2(TIMEOUT);
  localparam level_t MAX_LVL   = level_t'(MAX_LEVEL);
  localparam level_t START_LVL = level_t'(START_LEVEL);

  state_t            state;
  logic              puls_q;
  logic              armed;
  logic [CALM_W-1:0] calm_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic ev;
  logic stress_ev;
  logic calm_ev;
  logic run;
  logic restart;

  // One evaluation per detector pulse, however long the pulse lasts.
  assign ev        = gelijkPuls & ~puls_q;
  assign stress_ev = ev & error & ~gedaald;
  assign calm_ev   = ev & gedaald & ~error;

  assign run     = (state == RUN) || (state == STEP);
  assign restart = (state == STEP);

  always_ff @(posedge slow or posedge resetSlower) begin
    if (resetSlower) puls_q <= 1'b0;
    else             puls_q <= gelijkPuls;
  end

  always_ff @(posedge slow or posedge resetSlower) begin
    if (resetSlower) begin
      state    <= IDLE;
      level    <= '0;
      busy     <= 1'b0;
      fault    <= 1'b0;
      armed    <= 1'b0;
      calm_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          level <= '0;
          // A new session needs enable to have been seen low first, so a
          // finished session does not immediately restart itself.
          if (!enable) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end

        START: begin
          level    <= START_LVL;
          calm_cnt <= '0;
          tmo_cnt  <= '0;
          state    <= RUN;
        end

        RUN: begin
          if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            state <= FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
            level <= '0;
          end else if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            level <= '0;
          end else begin
            tmo_cnt <= ev ? '0 : tmo_cnt + 1'b1;
            if (stress_ev) begin
              calm_cnt <= '0;
              if (level < MAX_LVL) begin
                level <= level + 1'b1;
                state <= STEP;
              end
            end else if (calm_ev) begin
              if (calm_cnt == CALM_W'(CALM_COUNT - 1)) begin
                calm_cnt <= '0;
                if (level != '0) begin
                  level <= level - 1'b1;
                  state <= STEP;
                end else begin
                  state <= DONE;
                end
              end else begin
                calm_cnt <= calm_cnt + 1'b1;
              end
            end
          end
        end

        // Settling cycle after a level change; pulses arriving here are lost.
        STEP: state <= RUN;

        DONE: begin
          busy  <= 1'b0;
          level <= '0;
          state <= IDLE;
        end

        FAULT: begin
          level <= '0;
          if (!enable) begin
            fault <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  swing_gen #(
    .BASE_HALF (BASE_HALF),
    .STEP_HALF (STEP_HALF)
  ) u_swing (
    .slow        (slow),
    .resetSlower (resetSlower),
    .level       (level),
    .run         (run),
    .restart     (restart),
    .swing       (swing)
  );

endmodule

// File: tb/tb_rock_intensity_ctrl.sv
// Self-checking bench for rock_intensity_ctrl: table-driven per-cycle
// vectors plus hand-written sequences for swing timing, timeout and reset.
module tb_rock_intensity_ctrl;

  logic       slow;
  logic       resetSlower;
  logic       enable;
  logic       gelijkPuls;
  logic       gedaald;
  logic       error;
  logic [2:0] level;
  logic       swing;
  logic       busy;
  logic       fault;

  int n_checks = 0;
  int n_passed = 0;

  typedef struct {
    logic en;
    logic gp;
    logic gd;
    logic er;
    int   lvl;
    logic bsy;
    logic flt;
  } vec_t;

  vec_t vq[$];

  rock_intensity_ctrl dut (
    .slow        (slow),
    .resetSlower (resetSlower),
    .enable      (enable),
    .gelijkPuls  (gelijkPuls),
    .gedaald     (gedaald),
    .error       (error),
    .level       (level),
    .swing       (swing),
    .busy        (busy),
    .fault       (fault)
  );

  initial slow = 1'b0;
  always #5 slow = ~slow;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge slow);
    #1;
  endtask

  function automatic void add(input logic en, input logic gp, input logic gd,
                              input logic er, input int lvl, input logic bsy);
    vec_t v;
    v.en = en; v.gp = gp; v.gd = gd; v.er = er;
    v.lvl = lvl; v.bsy = bsy; v.flt = 1'b0;
    vq.push_back(v);
  endfunction

  // A detector pulse of len cycles followed by gap idle cycles, all inside
  // an active session; level is the expected intensity after the event.
  function automatic void add_pulse(input logic gd, input logic er,
                                    input int len, input int gap, input int lvl);
    for (int i = 0; i < len; i++) add(1'b1, 1'b1, gd, er, lvl, 1'b1);
    for (int i = 0; i < gap; i++) add(1'b1, 1'b0, 1'b0, 1'b0, lvl, 1'b1);
  endfunction

  task automatic apply_vectors(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      enable     = vq[i].en;
      gelijkPuls = vq[i].gp;
      gedaald    = vq[i].gd;
      error      = vq[i].er;
      tick();
      check($sformatf("%s[%0d].level", tag, i), int'(level), vq[i].lvl);
      check($sformatf("%s[%0d].busy",  tag, i), int'(busy),  int'(vq[i].bsy));
      check($sformatf("%s[%0d].fault", tag, i), int'(fault), int'(vq[i].flt));
    end
    vq.delete();
    gelijkPuls = 1'b0;
    gedaald    = 1'b0;
    error      = 1'b0;
  endtask

  // Cycles until swing changes value (bounded).
  task automatic wait_toggle(output int n);
    logic s0;
    s0 = swing;
    n  = 0;
    while (swing == s0 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Drop enable for one cycle, raise it, expect START then RUN at START_LEVEL.
  task automatic start_session(input string tag);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    check({tag, ".start_busy"},  int'(busy),  1);
    check({tag, ".start_level"}, int'(level), 0);
    tick();
    check({tag, ".run_level"},   int'(level), 3);
    check({tag, ".run_busy"},    int'(busy),  1);
  endtask

  initial begin
    int n;
    int calm_er [9];
    int calm_lvl[9];
    int err_lvl [5];

    calm_er  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    calm_lvl = '{3, 2, 2, 1, 1, 1, 0, 0, 0};
    err_lvl  = '{4, 5, 6, 7, 7};

    resetSlower = 1'b1;
    enable      = 1'b0;
    gelijkPuls  = 1'b0;
    gedaald     = 1'b0;
    error       = 1'b0;
    tick();
    tick();
    check("reset.level", int'(level), 0);
    check("reset.swing", int'(swing), 0);
    check("reset.busy",  int'(busy),  0);
    check("reset.fault", int'(fault), 0);
    resetSlower = 1'b0;

    // Session start and swing rate at level 3 (half-period 16-3*2 = 10).
    start_session("t1");
    wait_toggle(n);
    check("t1.first_half", n, 10);
    check("t1.swing_high", int'(swing), 1);
    wait_toggle(n);
    check("t1.second_half", n, 10);

    // Five 3-cycle error pulses: one step each, saturating at 7.
    for (int p = 0; p < 5; p++) add_pulse(1'b0, 1'b1, 3, 2, err_lvl[p]);
    apply_vectors("t2");
    wait_toggle(n);
    wait_toggle(n);
    check("t2.half_l7_a", n, 2);
    wait_toggle(n);
    check("t2.half_l7_b", n, 2);

    // Timeout: a neutral pulse restarts the count, then 64 silent cycles.
    add(1'b1, 1'b1, 1'b1, 1'b1, 7, 1'b1);
    apply_vectors("t4pre");
    for (int i = 0; i < 63; i++) tick();
    check("t4.no_fault_yet", int'(fault), 0);
    check("t4.level_held",   int'(level), 7);
    tick();
    check("t4.fault",      int'(fault), 1);
    check("t4.fault_lvl",  int'(level), 0);
    check("t4.fault_swg",  int'(swing), 0);
    check("t4.fault_busy", int'(busy),  0);
    tick();
    check("t4.fault_held", int'(fault), 1);
    enable = 1'b0;
    tick();
    check("t4.cleared",    int'(fault), 0);
    check("t4.idle_busy",  int'(busy),  0);

    // Calming down from level 3 to DONE, with a neutral 1,1 pulse inside.
    start_session("t3");
    for (int p = 0; p < 8; p++)
      add_pulse(1'b1, calm_er[p][0], 1, 2, calm_lvl[p]);
    add(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);  // DONE
    add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);  // IDLE
    add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);  // stays IDLE: enable never dropped
    add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    apply_vectors("t3");

    // Asynchronous reset mid-RUN at level 5 while swing is high.
    start_session("t5");
    add_pulse(1'b0, 1'b1, 3, 2, 4);
    add_pulse(1'b0, 1'b1, 3, 2, 5);
    apply_vectors("t5");
    n = 0;
    while (swing == 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check("t5.pre_swing", int'(swing), 1);
    check("t5.pre_level", int'(level), 5);
    #2;
    resetSlower = 1'b1;
    #1;
    check("t5.async_level", int'(level), 0);
    check("t5.async_swing", int'(swing), 0);
    check("t5.async_busy",  int'(busy),  0);
    check("t5.async_fault", int'(fault), 0);
    tick();
    resetSlower = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t5.no_restart", int'(busy), 0);
    start_session("t5b");

    // Abort and an error pulse in the same cycle: abort wins.
    add(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    apply_vectors("t6");
    check("t6.swing", int'(swing), 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
